// File: rtl/lock_key_loader_kat.sv
// Serial key loader and KAT-gated unlock front end for an XOR-locked adder.
// A key is shifted in MSB first, applied in one update, then verified with a known-answer test.
module lock_key_loader_kat #(
    parameter int unsigned KEY_W = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETTLE_CYC = 4,
    parameter logic [DATA_W-1:0] KAT_A = 32'h29AF2430,
    parameter logic [DATA_W-1:0] KAT_B = 32'h7A1B9ABC,
    parameter logic [DATA_W:0] KAT_SUM = 33'h0A3CABEEC
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              key_bit_i,
    input  logic              key_bit_valid_i,
    output logic              key_bit_ready_o,
    output logic [KEY_W-1:0]  keyinput_o,
    output logic [DATA_W-1:0] add1_o,
    output logic [DATA_W-1:0] add2_o,
    input  logic [DATA_W:0]   result_i,
    input  logic [DATA_W-1:0] user_add1_i,
    input  logic [DATA_W-1:0] user_add2_i,
    output logic [DATA_W:0]   sum_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o
);

    localparam int unsigned CntW = $clog2(KEY_W) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(KEY_W - 1);
    localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

    if (KEY_W > 128 || (KEY_W & (KEY_W - 1)) != 0) begin : g_bad_key_w
        $error("KEY_W must be a power of two no larger than 128");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("SETTLE_CYC must be in 1..15");
    end

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StSettle,
        StCheck,
        StPass,
        StFail
    } state_e;

    state_e            state_q;
    logic [KEY_W-1:0]  shadow_q;
    logic [KEY_W-1:0]  shadow_next;
    logic [CntW-1:0]   bit_cnt_q;
    logic [3:0]        settle_cnt_q;
    logic              transfer;

    assign transfer    = key_bit_valid_i & key_bit_ready_o;
    assign shadow_next = {shadow_q[KEY_W-2:0], key_bit_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            shadow_q        <= '0;
            bit_cnt_q       <= '0;
            settle_cnt_q    <= '0;
            keyinput_o      <= '0;
            key_bit_ready_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle, StPass, StFail: begin
                    if (start_i) begin
                        state_q         <= StShift;
                        shadow_q        <= '0;
                        bit_cnt_q       <= '0;
                        key_bit_ready_o <= 1'b1;
                        busy_o          <= 1'b1;
                        pass_o          <= 1'b0;
                    end
                end
                StShift: begin
                    if (transfer) begin
                        shadow_q  <= shadow_next;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        // The adder only ever sees a complete key.
                        if (bit_cnt_q == LastBit) begin
                            keyinput_o      <= shadow_next;
                            settle_cnt_q    <= '0;
                            key_bit_ready_o <= 1'b0;
                            state_q         <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_q <= StCheck;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    if (result_i == KAT_SUM) begin
                        state_q <= StPass;
                        pass_o  <= 1'b1;
                    end else begin
                        state_q <= StFail;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        add1_o = '0;
        add2_o = '0;
        sum_o  = '0;
        unique case (state_q)
            StSettle, StCheck: begin
                add1_o = KAT_A;
                add2_o = KAT_B;
            end
            StPass: begin
                add1_o = user_add1_i;
                add2_o = user_add2_i;
                sum_o  = result_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lock_key_loader_kat.sv
// Directed bench for lock_key_loader_kat with a behavioural locked-adder model.
// Expected verdicts and sums are queued at stimulus time and popped at the output.
module tb_lock_key_loader_kat;

    localparam logic [63:0] GoodKey = 64'h33DDEAB695CA827B;
    localparam logic [32:0] LockMask = 33'h1_0000_0040;
    localparam logic [31:0] KatA = 32'h29AF2430;
    localparam logic [31:0] KatB = 32'h7A1B9ABC;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        key_bit_i;
    logic        key_bit_valid_i;
    logic        key_bit_ready_o;
    logic [63:0] keyinput_o;
    logic [31:0] add1_o;
    logic [31:0] add2_o;
    logic [32:0] result_i;
    logic [31:0] user_add1_i;
    logic [31:0] user_add2_i;
    logic [32:0] sum_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] prev_key;
    bit exp_pass_q[$];
    logic [32:0] exp_sum_q[$];

    lock_key_loader_kat dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .key_bit_i       (key_bit_i),
        .key_bit_valid_i (key_bit_valid_i),
        .key_bit_ready_o (key_bit_ready_o),
        .keyinput_o      (keyinput_o),
        .add1_o          (add1_o),
        .add2_o          (add2_o),
        .result_i        (result_i),
        .user_add1_i     (user_add1_i),
        .user_add2_i     (user_add2_i),
        .sum_o           (sum_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o)
    );

    always #5 clk_i = ~clk_i;

    // Locked adder: exact sum only under the correct key.
    always_comb begin
        result_i = {1'b0, add1_o} + {1'b0, add2_o};
        if (keyinput_o != GoodKey) result_i = result_i ^ LockMask;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checkw({tag, "_key"}, 65'(keyinput_o), 65'(0));
        checkw({tag, "_add1"}, 65'(add1_o), 65'(0));
        checkw({tag, "_add2"}, 65'(add2_o), 65'(0));
        checkw({tag, "_sum"}, 65'(sum_o), 65'(0));
        check1({tag, "_ready"}, key_bit_ready_o, 1'b0);
        check1({tag, "_busy"}, busy_o, 1'b0);
        check1({tag, "_done"}, done_o, 1'b0);
        check1({tag, "_pass"}, pass_o, 1'b0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic load_key(input logic [63:0] key, input bit toggle, input bit poke_start,
                            input bit exp_pass);
        int cyc;
        int stalls;
        int n;
        bit verdict;
        logic [63:0] old_key;
        old_key = prev_key;
        exp_pass_q.push_back(exp_pass);
        pulse_start();
        cyc = 1;
        stalls = 0;
        check1("shift_ready", key_bit_ready_o, 1'b1);
        check1("shift_busy", busy_o, 1'b1);
        check1("shift_pass_low", pass_o, 1'b0);
        checkw("shift_sum_zero", 65'(sum_o), 65'(0));
        for (int i = 0; i < 64; i++) begin
            if (toggle) begin
                key_bit_valid_i = 1'b0;
                key_bit_i = ~key[63-i];
                @(posedge clk_i); #1;
                cyc++;
                stalls++;
            end
            key_bit_valid_i = 1'b1;
            key_bit_i = key[63-i];
            start_i = poke_start && (i == 10);
            @(posedge clk_i); #1;
            cyc++;
            start_i = 1'b0;
            if (i == 62) checkw("no_partial_key", 65'(keyinput_o), 65'(old_key));
        end
        key_bit_valid_i = 1'b0;
        prev_key = key;
        checkw("key_applied", 65'(keyinput_o), 65'(key));
        check1("settle_ready_low", key_bit_ready_o, 1'b0);
        check1("settle_busy", busy_o, 1'b1);
        checkw("settle_add1", 65'(add1_o), 65'(KatA));
        checkw("settle_add2", 65'(add2_o), 65'(KatB));
        if (poke_start) begin
            pulse_start();
            cyc++;
        end
        n = 0;
        while (!done_o && n < 40) begin
            @(posedge clk_i); #1;
            cyc++;
            n++;
        end
        check1("done_seen", done_o, 1'b1);
        checkw("latency", 65'(cyc), 65'(1 + 64 + stalls + 4 + 1));
        verdict = exp_pass_q.pop_front();
        check1("verdict", pass_o, verdict);
        check1("busy_after_check", busy_o, 1'b0);
        @(posedge clk_i); #1;
        check1("done_one_cycle", done_o, 1'b0);
        check1("pass_level", pass_o, verdict);
    endtask

    task automatic user_sum(input logic [31:0] a, input logic [31:0] b, input bit unlocked);
        logic [32:0] exp;
        user_add1_i = a;
        user_add2_i = b;
        exp_sum_q.push_back(unlocked ? ({1'b0, a} + {1'b0, b}) : 33'd0);
        #1;
        exp = exp_sum_q.pop_front();
        checkw("user_sum", 65'(sum_o), 65'(exp));
        checkw("user_add1", 65'(add1_o), 65'(unlocked ? a : 32'd0));
        checkw("user_add2", 65'(add2_o), 65'(unlocked ? b : 32'd0));
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        key_bit_i = 1'b0;
        key_bit_valid_i = 1'b0;
        user_add1_i = 32'h0;
        user_add2_i = 32'h0;
        prev_key = 64'h0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_idle_outputs("idle");

        // Correct key, valid held high.
        load_key(GoodKey, 1'b0, 1'b0, 1'b1);
        user_sum(32'h1111_4477, 32'hEEAA_0000, 1'b1);
        user_sum(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

        // Wrong key.
        load_key(64'h33DDEAB695CA823B, 1'b0, 1'b0, 1'b0);
        user_sum(32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        checkw("fail_keeps_key", 65'(keyinput_o), 65'(64'h33DDEAB695CA823B));

        // Correct key with valid toggling.
        load_key(GoodKey, 1'b1, 1'b0, 1'b1);
        user_sum(32'h0000_1234, 32'h0000_4321, 1'b1);

        // Reset in the middle of a shift.
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            key_bit_valid_i = 1'b1;
            key_bit_i = GoodKey[63-i];
            @(posedge clk_i); #1;
        end
        key_bit_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("abort");
        prev_key = 64'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        load_key(GoodKey, 1'b0, 1'b0, 1'b1);

        // Restart from PASS with a bad key, then recover; start pokes are ignored.
        load_key(64'h23DDEAB695CA827B, 1'b0, 1'b0, 1'b0);
        user_sum(32'h0F0F_0F0F, 32'h1010_1010, 1'b0);
        load_key(GoodKey, 1'b0, 1'b1, 1'b1);
        user_sum(32'h8000_0000, 32'h8000_0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
